// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, counter width and test-pattern colours
// for the VGA raster timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 4;

    localparam int CNT_W = 10;

    function automatic int calc_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;

    // Colour-bar order, left to right across the active line.
    function automatic logic [11:0] bar_colour(logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_ce_gen.sv
// Pixel-rate strobe derived from the system clock: div_cnt runs 0..CLK_DIV-1
// while en is high; pix_ce marks the last divider cycle of each pixel.
module pixel_ce_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic en,
    output logic pix_ce
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Gated by en so a strobe is withdrawn in the same cycle en drops.
    assign pix_ce = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 640x480@60, 4 system clocks per pixel).
// Define VGA_TIMING_TEST_PATTERN_EN to add an 8-bar colour test pattern on rgb.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    output logic             pix_ce,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [11:0]      rgb
`endif
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic SYNC_IDLE = ~SYNC_ACTIVE_HIGH;

    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic             hs_next;
    logic             vs_next;
    logic             de_next;

    pixel_ce_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_ce_gen (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .en      (en),
        .pix_ce  (pix_ce)
    );

    // Everything registered is decoded from the post-advance position so the
    // outputs change together on the edge that ends the strobe cycle.
    always_comb begin
        x_next = (x == H_LAST) ? '0 : x + CNT_W'(1);
        y_next = y;
        if (x == H_LAST) begin
            y_next = (y == V_LAST) ? '0 : y + CNT_W'(1);
        end
        hs_next = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
        vs_next = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
        de_next = (x_next < H_ACT) && (y_next < V_ACT);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            x           <= H_LAST;
            y           <= V_LAST;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                x           <= x_next;
                y           <= y_next;
                hsync       <= hs_next ^ SYNC_IDLE;
                vsync       <= vs_next ^ SYNC_IDLE;
                de          <= de_next;
                line_start  <= (x_next == '0);
                frame_start <= (x_next == '0) && (y_next == '0);
            end
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;

    always_comb begin
        bar_idx = 3'(x_next / CNT_W'(BAR_W));
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rgb <= RGB_BLACK;
        end else if (pix_ce) begin
            rgb <= de_next ? bar_colour(bar_idx) : RGB_BLACK;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance plus a tiny
// 16x8 raster instance (active-high syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic       clk_in;
    logic       reset_n;
    logic       en;

    logic       pix_ce, hsync, vsync, de, line_start, frame_start;
    logic [9:0] x, y;
    logic       pix_ce_s, hsync_s, vsync_s, de_s, line_start_s, frame_start_s;
    logic [9:0] x_s, y_s;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0] rgb, rgb_s;
`endif

    int total = 0;
    int bad   = 0;

    vga_timing_gen dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .en          (en),
        .pix_ce      (pix_ce),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .rgb         (rgb)
`endif
    );

    // Small raster: H 8/2/3/3 (total 16, hsync x=10..12), V 4/1/2/1 (total 8,
    // vsync y=5..6), 2 clocks per pixel -> 32-cycle lines, 256-cycle frames.
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .CLK_DIV (2), .SYNC_ACTIVE_HIGH (1'b1)
    ) dut_s (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .en          (en),
        .pix_ce      (pix_ce_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .de          (de_s),
        .x           (x_s),
        .y           (y_s),
        .line_start  (line_start_s),
        .frame_start (frame_start_s)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .rgb         (rgb_s)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk_in);
        #1;
        en      = 1'b1;
        reset_n = 1'b1;
    endtask

    task automatic wait_xy(input logic [9:0] tx, input logic [9:0] ty, input int budget,
                           output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (x == tx && y == ty) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        en      = 1'b0;
        #2;
        reset_n = 1'b0;
        #2;
        total++; if (x !== 10'd799) begin bad++; $display("FAIL reset_x got=%0d exp=799", x); end
        total++; if (y !== 10'd524) begin bad++; $display("FAIL reset_y got=%0d exp=524", y); end
        total++; if (de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b exp=0", de); end
        total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
        total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
        total++; if (pix_ce !== 1'b0) begin bad++; $display("FAIL reset_pix_ce got=%b exp=0", pix_ce); end
        total++; if ({line_start, frame_start} !== 2'b00) begin
            bad++; $display("FAIL reset_pulses got=%b exp=00", {line_start, frame_start});
        end
        total++; if ({x_s, y_s} !== {10'd15, 10'd7}) begin
            bad++; $display("FAIL reset_small_xy got=%0d,%0d exp=15,7", x_s, y_s);
        end
        total++; if ({hsync_s, vsync_s} !== 2'b00) begin
            bad++; $display("FAIL reset_small_sync got=%b exp=00", {hsync_s, vsync_s});
        end
    endtask

    task automatic test_first_pixel();
        release_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k < 3) begin
                total++; if (pix_ce !== 1'b0) begin
                    bad++; $display("FAIL early_pix_ce cycle=%0d got=%b exp=0", k, pix_ce);
                end
            end
        end
        total++; if (pix_ce !== 1'b1) begin bad++; $display("FAIL first_pix_ce got=%b exp=1", pix_ce); end
        total++; if (x !== 10'd799) begin bad++; $display("FAIL first_pix_hold_x got=%0d exp=799", x); end
        tick();
        total++; if ({x, y} !== 20'd0) begin bad++; $display("FAIL origin_xy got=%0d,%0d exp=0,0", x, y); end
        total++; if ({de, frame_start, line_start} !== 3'b111) begin
            bad++; $display("FAIL origin_flags got=%b exp=111", {de, frame_start, line_start});
        end
        total++; if (pix_ce !== 1'b0) begin bad++; $display("FAIL origin_pix_ce got=%b exp=0", pix_ce); end
        tick();
        total++; if ({frame_start, line_start} !== 2'b00) begin
            bad++; $display("FAIL origin_pulse_len got=%b exp=00", {frame_start, line_start});
        end
    endtask

    task automatic test_line();
        int cycles = 1;
        int hs_cycles = 0;
        int de_pix = 0;
        int hs_first_x = -1;
        bit got_line = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            cycles++;
            if (hsync === 1'b0) begin
                hs_cycles++;
                if (hs_first_x < 0) hs_first_x = int'(x);
            end
            if (pix_ce === 1'b1 && de === 1'b1) de_pix++;
            if (line_start === 1'b1) begin
                got_line = 1'b1;
                break;
            end
        end
        total++; if (!got_line) begin bad++; $display("FAIL line_timeout got=none exp=line_start"); end
        total++; if (cycles != 3200) begin bad++; $display("FAIL line_period got=%0d exp=3200", cycles); end
        total++; if (hs_cycles != 384) begin bad++; $display("FAIL hsync_width got=%0d exp=384", hs_cycles); end
        total++; if (hs_first_x != 656) begin bad++; $display("FAIL hsync_start_x got=%0d exp=656", hs_first_x); end
        total++; if (de_pix != 640) begin bad++; $display("FAIL de_pixels got=%0d exp=640", de_pix); end
        total++; if ({x, y} !== {10'd0, 10'd1}) begin
            bad++; $display("FAIL line_wrap_xy got=%0d,%0d exp=0,1", x, y);
        end
    endtask

    task automatic test_en_hold();
        bit found;
        bit pix_seen = 1'b0;
        bit x_moved = 1'b0;
        wait_xy(10'd100, 10'd1, 1000, found);
        total++; if (!found) begin bad++; $display("FAIL en_wait_x100 got=timeout exp=x100"); end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pix_ce !== 1'b0) pix_seen = 1'b1;
            if (x !== 10'd100) x_moved = 1'b1;
        end
        total++; if (pix_seen) begin bad++; $display("FAIL en_low_pix_ce got=1 exp=0"); end
        total++; if (x_moved) begin bad++; $display("FAIL en_low_x_hold got=moved exp=100"); end
        en = 1'b1;
        tick(); tick(); tick();
        total++; if ({pix_ce, x} !== {1'b1, 10'd100}) begin
            bad++; $display("FAIL en_resume_ce got=%b,%0d exp=1,100", pix_ce, x);
        end
        tick();
        total++; if (x !== 10'd101) begin bad++; $display("FAIL en_resume_x got=%0d exp=101", x); end
        tick(); tick(); tick();
        en = 1'b0;
        #1;
        total++; if (pix_ce !== 1'b0) begin bad++; $display("FAIL en_drop_suppress got=%b exp=0", pix_ce); end
        tick();
        total++; if (x !== 10'd101) begin bad++; $display("FAIL en_drop_no_adv got=%0d exp=101", x); end
        en = 1'b1;
        #1;
        total++; if (pix_ce !== 1'b1) begin bad++; $display("FAIL en_back_ce got=%b exp=1", pix_ce); end
        tick();
        total++; if (x !== 10'd102) begin bad++; $display("FAIL en_back_x got=%0d exp=102", x); end
    endtask

    task automatic test_reset_mid();
        bit found;
        wait_xy(10'd300, 10'd1, 2000, found);
        total++; if (!found) begin bad++; $display("FAIL mid_wait_x300 got=timeout exp=x300"); end
        total++; if (de !== 1'b1) begin bad++; $display("FAIL mid_pre_de got=%b exp=1", de); end
        #3;
        reset_n = 1'b0;
        #1;
        total++; if ({x, y} !== {10'd799, 10'd524}) begin
            bad++; $display("FAIL mid_reset_xy got=%0d,%0d exp=799,524", x, y);
        end
        total++; if ({de, hsync, vsync} !== 3'b011) begin
            bad++; $display("FAIL mid_reset_outs got=%b exp=011", {de, hsync, vsync});
        end
        total++; if ({x_s, y_s} !== {10'd15, 10'd7}) begin
            bad++; $display("FAIL mid_reset_small got=%0d,%0d exp=15,7", x_s, y_s);
        end
    endtask

    task automatic test_frame_small();
        bit started = 1'b0;
        release_reset();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_start_s === 1'b1) begin
                started = 1'b1;
                break;
            end
        end
        total++; if (!started) begin bad++; $display("FAIL small_start got=timeout exp=frame_start"); end
        for (int f = 0; f < 2; f++) begin
            int cycles = 0;
            int vs_cnt = 0;
            int pix = 0;
            int lines = 0;
            bit vs_bad = 1'b0;
            bit hs_bad = 1'b0;
            bit de_bad = 1'b0;
            bit done = 1'b0;
            for (int i = 0; i < 400; i++) begin
                tick();
                cycles++;
                if (vsync_s === 1'b1) vs_cnt++;
                if (vsync_s !== (y_s >= 10'd5 && y_s <= 10'd6)) vs_bad = 1'b1;
                if (hsync_s !== (x_s >= 10'd10 && x_s <= 10'd12)) hs_bad = 1'b1;
                if (de_s !== (x_s < 10'd8 && y_s < 10'd4)) de_bad = 1'b1;
                if (pix_ce_s === 1'b1 && de_s === 1'b1) pix++;
                if (line_start_s === 1'b1) lines++;
                if (frame_start_s === 1'b1) begin
                    done = 1'b1;
                    break;
                end
            end
            total++; if (!done) begin bad++; $display("FAIL small_frame%0d_timeout got=none exp=frame_start", f); end
            total++; if (cycles != 256) begin bad++; $display("FAIL small_frame%0d_period got=%0d exp=256", f, cycles); end
            total++; if (vs_cnt != 64) begin bad++; $display("FAIL small_frame%0d_vsync_len got=%0d exp=64", f, vs_cnt); end
            total++; if (vs_bad) begin bad++; $display("FAIL small_frame%0d_vsync_lines got=wrong exp=y5..6", f); end
            total++; if (hs_bad) begin bad++; $display("FAIL small_frame%0d_hsync_pos got=wrong exp=x10..12", f); end
            total++; if (de_bad) begin bad++; $display("FAIL small_frame%0d_de_area got=wrong exp=8x4", f); end
            total++; if (pix != 32) begin bad++; $display("FAIL small_frame%0d_de_pixels got=%0d exp=32", f, pix); end
            total++; if (lines != 8) begin bad++; $display("FAIL small_frame%0d_lines got=%0d exp=8", f, lines); end
        end
    endtask

`ifdef VGA_TIMING_TEST_PATTERN_EN
    task automatic test_pattern();
        bit found;
        logic [9:0] px [5];
        logic [11:0] exp_rgb [5];
        px[0] = 10'd0;   exp_rgb[0] = 12'hFFF;
        px[1] = 10'd80;  exp_rgb[1] = 12'hFF0;
        px[2] = 10'd160; exp_rgb[2] = 12'h0FF;
        px[3] = 10'd639; exp_rgb[3] = 12'h000;
        px[4] = 10'd700; exp_rgb[4] = 12'h000;
        reset_n = 1'b0;
        #2;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL rgb_reset got=%h exp=000", rgb); end
        release_reset();
        for (int k = 0; k < 5; k++) begin
            wait_xy(px[k], 10'd10, 40000, found);
            total++; if (!found || rgb !== exp_rgb[k]) begin
                bad++; $display("FAIL rgb_x%0d got=%h exp=%h", px[k], rgb, exp_rgb[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_pixel();
        test_line();
        test_en_hold();
        test_reset_mid();
        test_frame_small();
`ifdef VGA_TIMING_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
